// File: rtl/vga_pkg.sv
// Types shared by the SRAM arbiter and the VGA output block:
// the arbiter state encoding and the vga_state phase codes.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_RD   = 2'd1,
    CPU_XFER = 2'd2,
    ABORT    = 2'd3
  } arb_state_t;

  localparam logic [1:0] VGA_STATE_INACTIVE = 2'd0;
  localparam logic [1:0] VGA_STATE_PREP     = 2'd1;
  localparam logic [1:0] VGA_STATE_ACTIVE   = 2'd2;

  localparam int TMO_CNT_W = 8;

  function automatic logic is_sram_state(input arb_state_t s);
    return (s == VGA_RD) || (s == CPU_XFER);
  endfunction

endpackage

// File: rtl/vga_word_cache.sv
// One-word read cache for VGA pixel fetches: tag/data/valid registers, a hit compare
// on the fetch address and a snoop compare used to drop the word on CPU writes.
module vga_word_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_match,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv
);

  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  // Invalidate beats fill so a fill landing in an inactive frame is not kept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      if (fill) begin
        addr_reg <= fill_addr;
        data_reg <= fill_data;
      end
      if (inv) begin
        valid_reg <= 1'b0;
      end else if (fill) begin
        valid_reg <= 1'b1;
      end
    end
  end

  assign hit         = lookup_en && valid_reg && (lookup_addr == addr_reg);
  assign hit_data    = hit ? data_reg : '0;
  assign snoop_match = valid_reg && (snoop_addr == addr_reg);

endmodule

// File: rtl/vga_sram_arbiter.sv
// Shares the single-port SRAM between the CPU data port and the VGA pixel fetcher.
// VGA misses win arbitration; a one-word cache absorbs repeated pixel fetches.
module vga_sram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_sel,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic [1:0]        vga_state,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_busy,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [3:0]        sram_sel,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_busy,
  output logic              timeout_err
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_t           state_reg;
  logic [TMO_CNT_W-1:0] tmo_cnt_reg;
  logic [ADDR_W-1:0]    vga_addr_reg;
  logic [ADDR_W-1:0]    cpu_addr_reg;
  logic [DATA_W-1:0]    cpu_wdata_reg;
  logic [3:0]           cpu_sel_reg;
  logic                 cpu_we_reg;
  logic                 abort_cpu_reg;

  logic              cache_hit;
  logic [DATA_W-1:0] cache_data;
  logic              cache_snoop;
  logic              cache_inv;
  logic              vga_miss;
  logic              xfer_active;
  logic              vga_done;
  logic              cpu_done;
  logic              tmo_expire;
  logic              cpu_grant;

  assign vga_miss    = vga_req && !cache_hit;
  assign xfer_active = is_sram_state(state_reg);
  assign vga_done    = (state_reg == VGA_RD) && !sram_busy;
  assign cpu_done    = (state_reg == CPU_XFER) && !sram_busy;
  assign tmo_expire  = xfer_active && sram_busy && (tmo_cnt_reg == TMO_LAST);
  // The line before active is locked out so the first pixel fetch never waits on the CPU.
  assign cpu_grant   = cpu_req && !vga_miss && (vga_state != VGA_STATE_PREP);

  assign cache_inv = (vga_state == VGA_STATE_INACTIVE)
                  || ((state_reg == VGA_RD) && tmo_expire)
                  || (cpu_done && cpu_we_reg && (|cpu_sel_reg) && cache_snoop);

  vga_word_cache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk         (clk),
    .nrst        (nrst),
    .lookup_en   (vga_req),
    .lookup_addr (vga_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .snoop_addr  (cpu_addr_reg),
    .snoop_match (cache_snoop),
    .fill        (vga_done),
    .fill_addr   (vga_addr_reg),
    .fill_data   (sram_rdata),
    .inv         (cache_inv)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      tmo_cnt_reg   <= '0;
      vga_addr_reg  <= '0;
      cpu_addr_reg  <= '0;
      cpu_wdata_reg <= '0;
      cpu_sel_reg   <= '0;
      cpu_we_reg    <= 1'b0;
      abort_cpu_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tmo_cnt_reg <= '0;
          if (vga_miss) begin
            state_reg    <= VGA_RD;
            vga_addr_reg <= vga_addr;
          end else if (cpu_grant) begin
            state_reg     <= CPU_XFER;
            cpu_addr_reg  <= cpu_addr;
            cpu_wdata_reg <= cpu_wdata;
            cpu_sel_reg   <= cpu_sel;
            cpu_we_reg    <= cpu_we;
          end
        end
        VGA_RD, CPU_XFER: begin
          if (!sram_busy) begin
            state_reg <= IDLE;
          end else if (tmo_expire) begin
            state_reg     <= ABORT;
            abort_cpu_reg <= (state_reg == CPU_XFER);
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ABORT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sram_req   = xfer_active;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_sel   = 4'h0;
    if (state_reg == VGA_RD) begin
      sram_addr = vga_addr_reg;
      sram_sel  = 4'hF;
    end else if (state_reg == CPU_XFER) begin
      sram_we   = cpu_we_reg;
      sram_addr = cpu_addr_reg;
      sram_sel  = cpu_sel_reg;
      if (cpu_we_reg) begin
        sram_wdata = cpu_wdata_reg;
      end
    end
  end

  // An aborted CPU transfer still completes towards the CPU, with zero data.
  assign cpu_ready   = cpu_done || ((state_reg == ABORT) && abort_cpu_reg);
  assign cpu_rdata   = (cpu_done && !cpu_we_reg) ? sram_rdata : '0;
  assign timeout_err = (state_reg == ABORT);

  assign vga_rdata = vga_done ? sram_rdata : cache_data;
  assign vga_busy  = !nrst || (vga_miss && !vga_done);

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Randomised and directed checks of vga_sram_arbiter against a transaction-level model.
module tb_vga_sram_arbiter;

  localparam int TMO = 255;
  localparam int K_NONE  = 0;
  localparam int K_VGA   = 1;
  localparam int K_CPU   = 2;
  localparam int K_ABORT = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_sel;
  logic        cpu_ready;
  logic [1:0]  vga_state;
  logic        vga_req;
  logic [31:0] vga_addr, vga_rdata;
  logic        vga_busy;
  logic        sram_req, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_sel;
  logic        sram_busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  vga_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vga_state(vga_state), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rdata(vga_rdata), .vga_busy(vga_busy),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_sel(sram_sel), .sram_rdata(sram_rdata),
    .sram_busy(sram_busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  logic        s_vga_req, s_busy;
  logic [31:0] s_vga_addr;
  logic [1:0]  s_vga_state;
  logic        cpu_pend;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_sel;

  // Reference model: cache contents plus the one outstanding SRAM transaction
  logic        m_c_valid;
  logic [31:0] m_c_addr, m_c_data;
  int          m_kind, m_busy_cnt;
  logic        m_abort_cpu, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;

  // Last observed DUT values for scenario-level checks
  logic        o_ready, o_err, o_sram_req, o_vga_busy;
  logic [31:0] o_sram_addr;

  task automatic model_reset();
    m_c_valid = 1'b0; m_c_addr = '0; m_c_data = '0;
    m_kind = K_NONE; m_busy_cnt = 0; m_abort_cpu = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_sel = '0;
  endtask

  task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_pend = 1'b1; c_we = we; c_addr = a; c_wdata = d; c_sel = s;
  endtask

  task automatic cycle();
    logic hit, done, e_ready, e_busy;
    logic [31:0] rd, e_addr, e_vdata;
    @(negedge clk);
    rd = $urandom;
    vga_req = s_vga_req; vga_addr = s_vga_addr; vga_state = s_vga_state;
    sram_busy = s_busy; sram_rdata = rd;
    cpu_req = cpu_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata; cpu_sel = c_sel;
    #1;
    hit  = s_vga_req && m_c_valid && (s_vga_addr == m_c_addr);
    done = (m_kind == K_VGA || m_kind == K_CPU) && !s_busy;
    e_ready = ((m_kind == K_CPU) && done) || ((m_kind == K_ABORT) && m_abort_cpu);
    e_busy  = s_vga_req && !hit && !((m_kind == K_VGA) && done);
    e_addr  = (m_kind == K_VGA || m_kind == K_CPU) ? m_addr : 32'h0;
    e_vdata = ((m_kind == K_VGA) && done) ? rd : (hit ? m_c_data : 32'h0);
    check_val("sram_req", 32'(sram_req), 32'(m_kind == K_VGA || m_kind == K_CPU));
    check_val("sram_we", 32'(sram_we), 32'((m_kind == K_CPU) && m_we));
    check_val("sram_addr", sram_addr, e_addr);
    check_val("sram_sel", 32'(sram_sel), (m_kind == K_VGA) ? 32'hF : ((m_kind == K_CPU) ? 32'(m_sel) : 32'h0));
    check_val("sram_wdata", sram_wdata, ((m_kind == K_CPU) && m_we) ? m_wdata : 32'h0);
    check_val("cpu_ready", 32'(cpu_ready), 32'(e_ready));
    check_val("cpu_rdata", cpu_rdata, ((m_kind == K_CPU) && done && !m_we) ? rd : 32'h0);
    check_val("timeout_err", 32'(timeout_err), 32'(m_kind == K_ABORT));
    check_val("vga_busy", 32'(vga_busy), 32'(e_busy));
    check_val("vga_rdata", vga_rdata, e_vdata);
    o_ready = cpu_ready; o_err = timeout_err; o_sram_req = sram_req;
    o_vga_busy = vga_busy; o_sram_addr = sram_addr;
    @(posedge clk);
    case (m_kind)
      K_NONE: begin
        if (s_vga_req && !hit) begin
          m_kind = K_VGA; m_addr = s_vga_addr; m_busy_cnt = 0;
        end else if (cpu_pend && s_vga_state != 2'd1) begin
          m_kind = K_CPU; m_addr = c_addr; m_we = c_we; m_wdata = c_wdata;
          m_sel = c_sel; m_busy_cnt = 0;
        end
      end
      K_VGA, K_CPU: begin
        if (!s_busy) begin
          if (m_kind == K_VGA) begin
            m_c_valid = 1'b1; m_c_addr = m_addr; m_c_data = rd;
          end else if (m_we && m_sel != 4'h0 && m_addr == m_c_addr) begin
            m_c_valid = 1'b0;
          end
          m_kind = K_NONE;
        end else begin
          m_busy_cnt++;
          if (m_busy_cnt == TMO) begin
            m_abort_cpu = (m_kind == K_CPU);
            if (m_kind == K_VGA) m_c_valid = 1'b0;
            m_kind = K_ABORT;
          end
        end
      end
      default: m_kind = K_NONE;
    endcase
    if (s_vga_state == 2'd0) m_c_valid = 1'b0;
    if (e_ready) cpu_pend = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_vga_busy"}, 32'(vga_busy), 32'h1);
    check_val({tag, "_sram_req"}, 32'(sram_req), 32'h0);
    check_val({tag, "_cpu_ready"}, 32'(cpu_ready), 32'h0);
    check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    check_val({tag, "_sram_addr"}, sram_addr, 32'h0);
    check_val({tag, "_vga_rdata"}, vga_rdata, 32'h0);
    check_val({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    int n_busy, n_req, rdy_idx, vrd_idx, err_idx;
    nrst = 1'b0;
    s_vga_req = 1'b1; s_vga_addr = 32'h10; s_vga_state = 2'd2; s_busy = 1'b0;
    cpu_pend = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_sel = '0;
    vga_req = 1'b1; vga_addr = 32'h10; vga_state = 2'd2; sram_busy = 1'b0; sram_rdata = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = '0; cpu_sel = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    cpu_req = 1'b0;
    @(posedge clk); #2 nrst = 1'b1;

    // 1: first fetch of 0x10 with two busy cycles, then served from the cache
    n_busy = 0;
    s_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); n_busy += int'(o_vga_busy); end
    s_busy = 1'b0;
    cycle(); n_busy += int'(o_vga_busy);
    check_val("t1_busy_cycles", 32'(n_busy), 32'd3);
    cycle();
    check_val("t1_hit_after_fill", 32'(o_vga_busy), 32'h0);

    // 2: 60 cycles of hits, CPU write completes in 1 + busy cycles
    n_busy = 0; n_req = 0; rdy_idx = -1;
    cpu_issue(1'b1, 32'h20, 32'hCAFE_0001, 4'hF);
    for (int i = 0; i < 60; i++) begin
      s_busy = (i >= 1 && i <= 3);
      cycle();
      n_busy += int'(o_vga_busy);
      if (o_sram_req && o_sram_addr == 32'h10) n_req++;
      if (o_ready && rdy_idx < 0) rdy_idx = i;
    end
    check_val("t2_vga_fetches", 32'(n_req), 32'd0);
    check_val("t2_vga_busy", 32'(n_busy), 32'd0);
    check_val("t2_cpu_latency", 32'(rdy_idx), 32'd4);

    // 3: VGA miss and CPU request together; VGA goes first
    s_busy = 1'b0; s_vga_addr = 32'h30; rdy_idx = -1; vrd_idx = -1;
    cpu_issue(1'b0, 32'h24, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_sram_req && o_sram_addr == 32'h30 && vrd_idx < 0) vrd_idx = i;
      if (o_ready && rdy_idx < 0) rdy_idx = i;
    end
    check_val("t3_vga_first", 32'(vrd_idx), 32'd1);
    check_val("t3_cpu_ready", 32'(rdy_idx), 32'd3);

    // 4: CPU locked out during the prep line
    s_vga_state = 2'd1; s_vga_req = 1'b0; n_req = 0;
    cpu_issue(1'b0, 32'h28, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin cycle(); n_req += int'(o_sram_req); end
    check_val("t4_prep_lockout", 32'(n_req), 32'd0);
    s_vga_state = 2'd2; s_vga_req = 1'b1; s_vga_addr = 32'h40; rdy_idx = -1; vrd_idx = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_sram_req && o_sram_addr == 32'h40 && vrd_idx < 0) vrd_idx = i;
      if (o_ready && rdy_idx < 0) rdy_idx = i;
    end
    check_val("t4_vga_first", 32'(vrd_idx), 32'd1);
    check_val("t4_cpu_ready", 32'(rdy_idx), 32'd3);

    // 5: CPU write to the cached word forces a refetch
    s_vga_addr = 32'h10;
    repeat (4) cycle();
    s_vga_req = 1'b0;
    cpu_issue(1'b1, 32'h10, 32'h1234_5678, 4'b0100);
    repeat (4) cycle();
    s_vga_req = 1'b1;
    cycle();
    check_val("t5_refetch_busy", 32'(o_vga_busy), 32'h1);
    repeat (3) cycle();

    // 6: stuck SRAM busy aborts the CPU transfer
    s_vga_req = 1'b0; s_busy = 1'b1; err_idx = -1; rdy_idx = -1;
    cpu_issue(1'b0, 32'h50, 32'h0, 4'hF);
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (o_err && err_idx < 0) err_idx = i;
      if (o_ready && rdy_idx < 0) rdy_idx = i;
    end
    check_val("t6_timeout_at", 32'(err_idx), 32'd256);
    check_val("t6_abort_ready", 32'(rdy_idx), 32'd256);
    s_busy = 1'b0;
    repeat (3) cycle();

    // Asynchronous reset in the middle of a CPU transfer
    s_busy = 1'b1;
    cpu_issue(1'b1, 32'h60, 32'h0BAD_F00D, 4'hF);
    repeat (3) cycle();
    @(negedge clk); #2 nrst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #2 nrst = 1'b1;
    model_reset();
    cpu_pend = 1'b0; s_busy = 1'b0;

    // Randomised traffic
    s_vga_state = 2'd2;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 49) == 0) s_vga_state = 2'($urandom_range(0, 2));
      s_vga_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) s_vga_addr = 32'h100 + $urandom_range(0, 3);
      s_busy = ($urandom_range(0, 2) == 0);
      if (!cpu_pend && $urandom_range(0, 2) == 0)
        cpu_issue(1'($urandom_range(0, 1)), 32'h100 + $urandom_range(0, 5), $urandom,
                  4'($urandom_range(0, 15)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
